// File: rtl/pll_rst_seq_if.sv
// pll_rst_seq_if
//   Bundles the lock-supervision signals between the PLL reset sequencer and
//   whatever drives/observes it.
//   locked_in         : PLL lock, already synchronized to the PLL output clock
//   clr_in            : one-cycle pulse clearing the unlock count and sticky flag
//   rst_core_out      : active-high reset for control/core logic
//   rst_dsp_out       : active-high reset for the audio/DAC datapath
//   ready_out         : both resets released and lock stable
//   unlock_cnt_out    : saturating count of counted lock losses
//   unlock_sticky_out : set on any counted lock loss
//   master modport drives the lock/clear side, slave modport is the sequencer.
interface pll_rst_seq_if;
  logic       locked_in;
  logic       clr_in;
  logic       rst_core_out;
  logic       rst_dsp_out;
  logic       ready_out;
  logic [7:0] unlock_cnt_out;
  logic       unlock_sticky_out;

  modport master (
    output locked_in,
    output clr_in,
    input  rst_core_out,
    input  rst_dsp_out,
    input  ready_out,
    input  unlock_cnt_out,
    input  unlock_sticky_out
  );

  modport slave (
    input  locked_in,
    input  clr_in,
    output rst_core_out,
    output rst_dsp_out,
    output ready_out,
    output unlock_cnt_out,
    output unlock_sticky_out
  );
endinterface

// File: rtl/pll_rst_seq.sv
// pll_rst_seq
//   Turns the PLL lock indication into an ordered reset release: core reset
//   first, then the DSP reset, then ready. Lock must be stable for LOCK_FILT
//   cycles before anything is released; each later step waits HOLD_CYC cycles.
//   After release, any loss of lock forces a full re-sequence and is recorded
//   in a saturating counter plus a sticky flag.
//   clock_in : PLL output clock (only clock)
//   rst_in   : synchronous active-high reset
//   lock_if  : slave side of pll_rst_seq_if (lock/clear in, resets/status out)
module pll_rst_seq #(
  parameter int LOCK_FILT = 1024,
  parameter int HOLD_CYC  = 256
) (
  input logic           clock_in,
  input logic           rst_in,
  pll_rst_seq_if.slave  lock_if
);

  localparam int MAX_CYC = (LOCK_FILT > HOLD_CYC) ? LOCK_FILT : HOLD_CYC;
  localparam int CW      = $clog2(MAX_CYC) + 1;

  localparam logic [CW-1:0] FILT_LAST = CW'(LOCK_FILT - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    WAIT_LOCK,
    FILTER,
    REL_CORE,
    REL_DSP,
    RUN
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lock_loss;
  logic [7:0]    unlock_cnt_q;
  logic          unlock_sticky_q;

  // State and shared cycle counter register.
  always_ff @(posedge clock_in) begin
    if (rst_in) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. A drop in FILTER is just an unstable lock and is not
  // counted; a drop once any reset has been released is a real loss.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lock_loss = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (lock_if.locked_in) state_d = FILTER;
      end
      FILTER: begin
        if (!lock_if.locked_in) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == FILT_LAST) begin
          state_d = REL_CORE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REL_CORE: begin
        if (!lock_if.locked_in) begin
          state_d   = WAIT_LOCK;
          cnt_d     = '0;
          lock_loss = 1'b1;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = REL_DSP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REL_DSP: begin
        if (!lock_if.locked_in) begin
          state_d   = WAIT_LOCK;
          cnt_d     = '0;
          lock_loss = 1'b1;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        cnt_d = '0;
        if (!lock_if.locked_in) begin
          state_d   = WAIT_LOCK;
          lock_loss = 1'b1;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  // Loss bookkeeping. The clear is written first so that a coinciding loss
  // overrides it, leaving count=1 rather than 0 or old+1.
  always_ff @(posedge clock_in) begin
    if (rst_in) begin
      unlock_cnt_q    <= 8'd0;
      unlock_sticky_q <= 1'b0;
    end else begin
      if (lock_if.clr_in) begin
        unlock_cnt_q    <= 8'd0;
        unlock_sticky_q <= 1'b0;
      end
      if (lock_loss) begin
        unlock_sticky_q <= 1'b1;
        if (lock_if.clr_in) begin
          unlock_cnt_q <= 8'd1;
        end else if (unlock_cnt_q != 8'hFF) begin
          unlock_cnt_q <= unlock_cnt_q + 8'd1;
        end
      end
    end
  end

  // Outputs decode from registered state only, so they never glitch with locked_in.
  assign lock_if.rst_core_out      = (state_q == WAIT_LOCK) || (state_q == FILTER);
  assign lock_if.rst_dsp_out       = (state_q == WAIT_LOCK) || (state_q == FILTER) ||
                                     (state_q == REL_CORE);
  assign lock_if.ready_out         = (state_q == RUN);
  assign lock_if.unlock_cnt_out    = unlock_cnt_q;
  assign lock_if.unlock_sticky_out = unlock_sticky_q;

endmodule

// File: tb/tb_pll_rst_seq.sv
// tb_pll_rst_seq
//   Directed bench for pll_rst_seq with LOCK_FILT=8, HOLD_CYC=4.
//   Stimulus tasks push expected output snapshots, tagged with the clock edge
//   after which they must hold, into a scoreboard queue; an independent
//   monitor on the falling edge pops and compares them.
module tb_pll_rst_seq;

  typedef struct {
    int          at;
    string       tag;
    logic [11:0] exp;
  } exp_t;

  logic clock_in;
  logic rst_in;
  int   cyc;
  int   total;
  int   bad;
  int   exp_cnt;
  bit   exp_sticky;
  exp_t sb[$];
  exp_t mon_e;

  // Release milestones for LOCK_FILT=8, HOLD_CYC=4, counted from the lock rise:
  // core falls at 9, dsp at 13, ready rises at 17. Value bits are {core,dsp,ready}.
  int       rel_cyc [7] = '{1, 8, 9, 12, 13, 16, 17};
  bit [2:0] rel_val [7] = '{3'b110, 3'b110, 3'b010, 3'b010, 3'b000, 3'b000, 3'b001};

  pll_rst_seq_if lock_if ();

  pll_rst_seq #(
    .LOCK_FILT (8),
    .HOLD_CYC  (4)
  ) dut (
    .clock_in (clock_in),
    .rst_in   (rst_in),
    .lock_if  (lock_if)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  // Edge counter; the value after edge k is k.
  always @(posedge clock_in) cyc <= cyc + 1;

  // Drive inputs on the falling edge; samp is the rising edge that samples them.
  task automatic applyStimulus(input bit lk, input bit cl, input bit rs, output int samp);
    @(negedge clock_in);
    lock_if.locked_in = lk;
    lock_if.clr_in    = cl;
    rst_in            = rs;
    samp              = cyc + 1;
  endtask

  task automatic pushExpect(input int at, input string tag, input bit core, input bit dsp,
                            input bit rdy);
    exp_t e;
    e.at  = at;
    e.tag = tag;
    e.exp = {core, dsp, rdy, exp_cnt[7:0], exp_sticky};
    sb.push_back(e);
  endtask

  task automatic lossModel(input bit cl);
    if (cl) exp_cnt = 1;
    else if (exp_cnt < 255) exp_cnt = exp_cnt + 1;
    exp_sticky = 1'b1;
  endtask

  // Hold lock high for n cycles (cycles 0..n-1 of a fresh sequence) and
  // optionally schedule the release milestones that fall inside that window.
  task automatic lockCycles(input int n, input bit chk, input string tag);
    int s;
    int c0;
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, s);
      if (i == 0) begin
        c0 = s;
        if (chk) begin
          for (int j = 0; j < 7; j++) begin
            if (rel_cyc[j] <= n)
              pushExpect(c0 + rel_cyc[j] - 1, $sformatf("%s_c%0d", tag, rel_cyc[j]),
                         rel_val[j][2], rel_val[j][1], rel_val[j][0]);
          end
        end
      end
    end
  endtask

  task automatic checkOutput(input exp_t e);
    logic [11:0] act;
    act = {lock_if.rst_core_out, lock_if.rst_dsp_out, lock_if.ready_out,
           lock_if.unlock_cnt_out, lock_if.unlock_sticky_out};
    total = total + 1;
    if (act !== e.exp) begin
      bad = bad + 1;
      $display("[TB] FAIL %s edge %0d: got core=%b dsp=%b rdy=%b cnt=%0d sticky=%b, want core=%b dsp=%b rdy=%b cnt=%0d sticky=%b",
               e.tag, e.at, act[11], act[10], act[9], act[8:1], act[0],
               e.exp[11], e.exp[10], e.exp[9], e.exp[8:1], e.exp[0]);
    end
  endtask

  // Monitor: compare every scoreboard entry due at the current edge.
  always @(negedge clock_in) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      mon_e = sb.pop_front();
      if (mon_e.at < cyc) begin
        total = total + 1;
        bad   = bad + 1;
        $display("[TB] FAIL %s: missed check at edge %0d, now %0d", mon_e.tag, mon_e.at, cyc);
      end else begin
        checkOutput(mon_e);
      end
    end
  end

  initial begin
    int s;
    cyc               = 0;
    total             = 0;
    bad               = 0;
    exp_cnt           = 0;
    exp_sticky        = 1'b0;
    rst_in            = 1'b1;
    lock_if.locked_in = 1'b0;
    lock_if.clr_in    = 1'b0;

    // Reset, then idle without lock.
    applyStimulus(1'b0, 1'b0, 1'b1, s);
    pushExpect(s, "reset", 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, s);
    applyStimulus(1'b0, 1'b0, 1'b0, s);
    pushExpect(s, "idle_no_lock", 1'b1, 1'b1, 1'b0);

    // Lock for 5 cycles, drop during FILTER: back to WAIT_LOCK, not counted.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, s);
    applyStimulus(1'b0, 1'b0, 1'b0, s);
    pushExpect(s, "filter_drop", 1'b1, 1'b1, 1'b0);
    lockCycles(17, 1'b1, "seq_after_glitch");

    // Single-cycle glitch in RUN: counted, full re-sequence.
    applyStimulus(1'b0, 1'b0, 1'b0, s);
    lossModel(1'b0);
    pushExpect(s, "run_glitch", 1'b1, 1'b1, 1'b0);
    lockCycles(17, 1'b1, "seq_after_loss");

    // 259 more losses from RUN: the counter must stop at 255.
    for (int i = 0; i < 259; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, s);
      lossModel(1'b0);
      pushExpect(s, $sformatf("loss_%0d", i + 2), 1'b1, 1'b1, 1'b0);
      lockCycles(17, 1'b0, "");
    end

    // Clear while in RUN: status cleared, FSM unaffected.
    applyStimulus(1'b1, 1'b1, 1'b0, s);
    exp_cnt    = 0;
    exp_sticky = 1'b0;
    pushExpect(s, "clr_after_sat", 1'b0, 1'b0, 1'b1);

    // One loss, then clear coinciding with a loss in REL_DSP.
    applyStimulus(1'b0, 1'b0, 1'b0, s);
    lossModel(1'b0);
    pushExpect(s, "loss_before_clr", 1'b1, 1'b1, 1'b0);
    lockCycles(14, 1'b1, "to_rel_dsp");
    applyStimulus(1'b0, 1'b1, 1'b0, s);
    lossModel(1'b1);
    pushExpect(s, "clr_with_loss", 1'b1, 1'b1, 1'b0);

    // Two losses in REL_CORE bring the count to 3.
    for (int i = 0; i < 2; i++) begin
      lockCycles(10, 1'b0, "");
      applyStimulus(1'b0, 1'b0, 1'b0, s);
      lossModel(1'b0);
      pushExpect(s, $sformatf("loss_rel_core_%0d", i), 1'b1, 1'b1, 1'b0);
    end

    // Reset in REL_DSP with count=3, then the sequence restarts on lock.
    lockCycles(14, 1'b0, "");
    applyStimulus(1'b1, 1'b0, 1'b1, s);
    exp_cnt    = 0;
    exp_sticky = 1'b0;
    pushExpect(s, "rst_mid_seq", 1'b1, 1'b1, 1'b0);
    lockCycles(18, 1'b1, "seq_after_rst");

    repeat (3) @(negedge clock_in);
    #1;
    if (sb.size() != 0) begin
      total = total + 1;
      bad   = bad + 1;
      $display("[TB] FAIL scoreboard_drain: pending=%0d, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pll_rst_seq.md
# pll_rst_seq

Consumer end of the PLL lock interface: takes the PLL's synchronized `locked` indication in the PLL output clock domain and turns it into an ordered, filtered reset release for the design. It also supervises the lock after release and records loss-of-lock events. Sits directly behind the PLL wrapper and drives the resets of the core logic and the audio DAC datapath.

## Interface
- `LOCK_FILT`, default 1024: consecutive cycles `locked_in` must stay high before any reset is released (>= 1).
- `HOLD_CYC`, default 256: cycles between the core reset release and the DSP reset release, and between the DSP reset release and `ready_out` (>= 1).

- `clock_in`  in  1  PLL output clock; the only clock.
- `rst_in`  in  1  synchronous, active-high reset.
- `locked_in`  in  1  PLL lock, already synchronized to `clock_in`.
- `clr_in`  in  1  one-cycle pulse; clears the unlock counter and the sticky flag.
- `rst_core_out`  out  1  active-high reset for control/core logic.
- `rst_dsp_out`  out  1  active-high reset for the audio/DAC datapath.
- `ready_out`  out  1  high when both resets are released and lock is stable.
- `unlock_cnt_out`  out  8  saturating count of counted lock losses.
- `unlock_sticky_out`  out  1  set on any counted lock loss.

## Operation
- FSM states: WAIT_LOCK, FILTER, REL_CORE, REL_DSP, RUN. One shared cycle counter, width `$clog2(max(LOCK_FILT,HOLD_CYC))+1`.
- WAIT_LOCK: counter held at 0. `locked_in`=1 -> FILTER.
- FILTER: counter increments each cycle while `locked_in`=1. Counter reaching `LOCK_FILT-1` with `locked_in`=1 -> REL_CORE with counter cleared. `locked_in`=0 -> WAIT_LOCK; this is not counted as a loss.
- REL_CORE: counts to `HOLD_CYC-1` -> REL_DSP with counter cleared.
- REL_DSP: counts to `HOLD_CYC-1` -> RUN.
- RUN: stays while `locked_in`=1.
- `locked_in`=0 in REL_CORE, REL_DSP or RUN -> WAIT_LOCK, counter cleared, and a counted lock loss.
- Output decode from the state register only (no combinational path from inputs):
  - `rst_core_out` = 1 in WAIT_LOCK and FILTER.
  - `rst_dsp_out` = 1 in WAIT_LOCK, FILTER and REL_CORE.
  - `ready_out` = 1 in RUN only.
- Counted lock loss: `unlock_cnt_out` increments, saturating at 255, and `unlock_sticky_out` is set.
- `clr_in` sets the count to 0 and clears the sticky flag. If `clr_in` coincides with a counted loss, the clear is applied first, giving count=1 and sticky=1.
- `clr_in` has no effect on the FSM.

## Timing
- `rst_in`=1 (sampled at a `clock_in` edge): next cycle state=WAIT_LOCK, counter=0, `rst_core_out`=1, `rst_dsp_out`=1, `ready_out`=0, `unlock_cnt_out`=0, `unlock_sticky_out`=0. `rst_in` overrides all other inputs, including mid-sequence.
- Cycle numbering: cycle 0 is the first cycle `locked_in`=1 is sampled in WAIT_LOCK, with `locked_in` held high throughout.
  - FILTER occupies cycles 1 .. `LOCK_FILT`.
  - `rst_core_out` falls at cycle `LOCK_FILT+1`.
  - `rst_dsp_out` falls at cycle `LOCK_FILT+1+HOLD_CYC`.
  - `ready_out` rises at cycle `LOCK_FILT+1+2*HOLD_CYC`.
- Loss of lock: `locked_in`=0 sampled at cycle t gives `rst_core_out`=`rst_dsp_out`=1 and `ready_out`=0 at cycle t+1. The counter and sticky flag update at t+1 as well.
- Lock returning at the same cycle the loss is processed does not shortcut the sequence: the full FILTER period repeats.
- Single-cycle `locked_in` low glitches in RUN are counted and force a full re-sequence; no glitch filtering after release.

## Test plan
- `LOCK_FILT`=8, `HOLD_CYC`=4, reset, then `locked_in` high from cycle 0 -> `rst_core_out` falls at cycle 9, `rst_dsp_out` at 13, `ready_out` rises at 17; count stays 0.
- `locked_in` high for 5 cycles then low for 1 during FILTER, then high -> back to WAIT_LOCK with no count. Release times are measured from the new rise (+9/+13/+17). `unlock_sticky_out`=0.
- In RUN, drop `locked_in` for 1 cycle at t -> at t+1 both resets are 1, `ready_out`=0, `unlock_cnt_out`=1, sticky=1. `ready_out` returns 17 cycles after lock reasserts.
- Force 260 lock losses from RUN -> `unlock_cnt_out` saturates at 255. `clr_in` pulse -> count 0, sticky 0 on the next cycle.
- `clr_in` asserted in the same cycle as a loss sampled in REL_DSP -> count=1, sticky=1.
- `rst_in` pulsed in REL_DSP with count=3 -> next cycle WAIT_LOCK outputs, count 0, sticky 0. Sequence restarts on `locked_in`.
